// File: rtl/dft_pkg.sv
// Constants and types shared by the DFT history writer, history reader and DFT core.
package dft_pkg;

  localparam int HIST_SIZE = 28;
  localparam int WORD_W    = 32;

  typedef enum logic {
    IDLE,
    STREAM
  } rd_state_e;

  // Entry i of a HIST_SIZE-entry flat history bus; entry 0 is the oldest.
  function automatic logic [WORD_W-1:0] flat_sel(
    input logic [HIST_SIZE*WORD_W-1:0] flat,
    input int unsigned                 i
  );
    return flat[i*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/history_window_reader_if.sv
// Stream bus from the history reader to the DFT accumulator (valid/ready).
interface history_window_reader_if #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 5
);
  logic [WORD_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, out_idx, out_last, out_valid, input out_ready);
  modport slave  (input out_data, out_idx, out_last, out_valid, output out_ready);
endinterface

// File: rtl/history_snapshot_buf.sv
// SIZE x WORD_W snapshot register bank with a stream-order read mux.
module history_snapshot_buf #(
  parameter int SIZE   = 28,
  parameter int WORD_W = 32,
  parameter int IDX_W  = $clog2(SIZE)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   load,
  input  logic [SIZE*WORD_W-1:0] hist_flat,
  input  logic                   rev,
  input  logic [IDX_W-1:0]       idx,
  output logic [WORD_W-1:0]      data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  logic [SIZE-1:0][WORD_W-1:0] snap;
  logic [IDX_W-1:0]            sel;

  for (genvar g = 0; g < SIZE; g++) begin : g_entry
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)     snap[g] <= '0;
      else if (load) snap[g] <= hist_flat[g*WORD_W +: WORD_W];
    end
  end

  // Stream position maps to the mirrored slot when reading newest first.
  assign sel  = rev ? (LAST_IDX - idx) : idx;
  assign data = snap[sel];

endmodule

// File: rtl/history_window_reader.sv
// Snapshots the history window on start and streams it one entry per handshake.
module history_window_reader #(
  parameter int SIZE   = dft_pkg::HIST_SIZE,
  parameter int WORD_W = dft_pkg::WORD_W,
  parameter int IDX_W  = $clog2(SIZE)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [SIZE*WORD_W-1:0]   hist_flat,
  input  logic                     start,
  input  logic                     newest_first,
  input  logic                     clr_overrun,
  history_window_reader_if.master  bus,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);
  import dft_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  rd_state_e         state, state_nxt;
  logic [IDX_W-1:0]  idx_q, idx_nxt;
  logic              rev_q, rev_nxt;
  logic              load, reject;
  logic              valid, is_last, fire;
  logic [WORD_W-1:0] buf_data;

  assign valid   = (state == STREAM);
  assign is_last = valid && (idx_q == LAST_IDX);
  assign fire    = valid && bus.out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      idx_q <= '0;
      rev_q <= 1'b0;
    end else begin
      state <= state_nxt;
      idx_q <= idx_nxt;
      rev_q <= rev_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    rev_nxt   = rev_q;
    load      = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
          rev_nxt   = newest_first;
          load      = 1'b1;
        end
      end
      STREAM: begin
        if (fire && is_last) begin
          idx_nxt = '0;
          // A start on the final transfer chains straight into the next window.
          if (start) begin
            rev_nxt = newest_first;
            load    = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (fire)  idx_nxt = idx_q + 1'b1;
          if (start) reject  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= fire && is_last;
      if (reject)           overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  history_snapshot_buf #(
    .SIZE   (SIZE),
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_snap (
    .clk       (clk),
    .rstn      (rstn),
    .load      (load),
    .hist_flat (hist_flat),
    .rev       (rev_q),
    .idx       (idx_q),
    .data      (buf_data)
  );

  assign bus.out_valid = valid;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = is_last;
  assign bus.out_data  = valid ? buf_data : '0;
  assign busy          = valid;

endmodule

// File: doc/history_window_reader.md
Name: history_window_reader

Overview:
- Read side of the DFT history buffer.
- On a start request, it snapshots the SIZE-entry IEEE754 history window from the shift-register writer. It then streams the entries one per handshake to the DFT accumulator, tagged with sample index and last flag.
- The snapshot decouples readout from further writer shifts, so new samples may arrive mid-readout without corrupting the current window.

Parameters:
SIZE, 28, number of history entries (window length); must be >= 2
WORD_W, 32, entry width (IEEE754 single-precision bit pattern, passed through untouched)
IDX_W, $clog2(SIZE), width of the index output

Ports:
clk  input  1  block clock; all state changes on posedge
rstn  input  1  asynchronous active-low reset (0: reset, 1: normal)
hist_flat  input  SIZE*WORD_W  history window, entry i at bits [i*WORD_W +: WORD_W]; entry 0 oldest, entry SIZE-1 newest
start  input  1  readout request, sampled on posedge clk
newest_first  input  1  read order, latched with start (0: oldest first, 1: newest first)
clr_overrun  input  1  clears the sticky overrun flag
out_data  output  WORD_W  current entry
out_idx  output  IDX_W  position in stream, 0..SIZE-1 (stream order, not array slot)
out_last  output  1  high with out_valid on the final entry
out_valid  output  1  out_data, out_idx and out_last are valid
out_ready  input  1  consumer accepts the current entry
busy  output  1  readout in progress
done  output  1  one-cycle pulse after the final transfer
overrun  output  1  sticky: start arrived while busy and was rejected

Behaviour:
- Reset (rstn=0, async): state IDLE; snapshot buffer all 32'b0; out_valid=0, out_last=0, out_idx=0, out_data=0, busy=0, done=0, overrun=0. Reset mid-stream aborts the stream immediately, with no done pulse.
- States: IDLE, STREAM.
- IDLE, start=1 at edge k:
  - Copy all SIZE entries of hist_flat into the snapshot and latch newest_first.
  - Enter STREAM; out_valid=1, busy=1, out_idx=0 after edge k.
  - Zero-cycle latency from the start edge to the first valid beat.
- STREAM:
  - out_data = snap[out_idx] when newest_first=0; snap[SIZE-1-out_idx] when newest_first=1.
  - out_last = (out_idx == SIZE-1).
  - Transfer occurs on an edge where out_valid && out_ready. out_idx then increments; otherwise all outputs hold stable (AXI-style; out_data must not change while stalled).
- Final transfer (out_last && out_ready):
  - done=1 for exactly one cycle after that edge.
  - If start=0 on that edge: return to IDLE with out_valid=0 and busy=0.
  - If start=1 on that same edge: back-to-back readout. Take a new snapshot, out_idx=0, and stay in STREAM with out_valid=1 and busy=1. overrun is not set.
- start=1 in STREAM on any edge other than the final transfer: ignored and overrun set to 1. The snapshot and stream are unaffected.
- Overrun clearing: clr_overrun=1 clears overrun. If a rejected start occurs on the same edge, set wins.
- hist_flat changes while busy have no effect on out_data.
- Consumer stall: out_ready held low indefinitely is legal; no timeout.
- No arithmetic on entries; out_idx wrap is never reached, because the index resets on a new start.
- Total readout with out_ready tied high: SIZE cycles of out_valid, done in cycle SIZE+1 after start.

Decomposition:
- Shared package dft_pkg:
  - constants HIST_SIZE=28 and WORD_W=32, shared with the history writer and the DFT core;
  - the reader state enum (IDLE, STREAM);
  - a function for flat-bus entry select.
- One natural sub-module: history_snapshot_buf. SIZE x WORD_W register bank with a load enable and a read-index mux, including order reversal. The FSM, handshake, index counter and flags stay in the top module.

Test Plan:
- Basic readout: hist entry i = 32'h40000000+i, newest_first=0, out_ready=1, start pulse. Expect 28 beats out_data 40000000..4000001B, out_idx 0..27, out_last only on beat 27, done one cycle later, busy low after.
- Reverse order: same window, newest_first=1. Expect first beat 4000001B with idx 0, last beat 40000000 with idx 27 and out_last=1.
- Backpressure and snapshot isolation: start, then toggle out_ready 1/0 every cycle and rewrite hist_flat to all 32'hFFFFFFFF after beat 3. Expect the original values 40000000..4000001B in order, each held stable while stalled, and done after the 28th accepted beat.
- Overrun: start at beat 5 of a stream. Expect the stream to continue unchanged and overrun=1 sticky. Then clr_overrun pulse gives overrun=0; clr_overrun and a rejected start on the same edge leave overrun=1.
- Back-to-back: start asserted on the final-transfer edge with hist_flat changed to 32'h3F800000+i. Expect done pulse, busy stays 1, next beat idx 0 with out_data 3F800000, and overrun stays 0.
- Async reset mid-stream: rstn low at beat 10 without a clock edge. Expect out_valid, busy, done and overrun = 0 immediately and snapshot zeroed. The next start after rstn=1 streams the current hist_flat from idx 0.
